hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It sits beside the forwarding unit and generates the stall, hold, bubble and flush controls for the PC and the IF/ID, ID/EX and EX/MEM registers. It covers three cases: load-use hazards that forwarding cannot cover, taken branches resolved in ID, and multi-cycle MUL/DIV occupancy of EX. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- MUL_LAT, 4, total EX occupancy in cycles of a MUL-class instruction (≥1)
- DIV_LAT, 32, total EX occupancy in cycles of a DIV/REM-class instruction (≥1)

- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- RS1Addr_ID  in  5  rs1 of instruction in ID
- RS2Addr_ID  in  5  rs2 of instruction in ID
- RDAddr_EX  in  5  rd of instruction in EX
- MemRead_EX  in  1  instruction in EX is a load
- BranchTaken_ID  in  1  branch in ID resolved taken
- MulDiv_EX  in  1  instruction in EX is MUL/DIV class
- IsDiv_EX  in  1  qualifies MulDiv_EX: 1 = DIV/REM, 0 = MUL
- PCWrite_o  out  1  PC update enable
- IF_ID_Write_o  out  1  IF/ID register write enable
- IF_ID_Flush_o  out  1  zero IF/ID (NOP) on next edge
- ID_EX_Bubble_o  out  1  load NOP into ID/EX on next edge
- EX_Hold_o  out  1  ID/EX register and EX operand latches hold
- EX_MEM_Bubble_o  out  1  load NOP into EX/MEM on next edge
- stall_cnt_o  out  16  saturating count of cycles with PCWrite_o=0

## Operation
- State: FSM {IDLE, BUSY}, down-counter cnt (6 bits, sized for max(MUL_LAT, DIV_LAT)-1), stall_cnt.
- Load-use (lu): MemRead_EX & RDAddr_EX≠0 & (RDAddr_EX==RS1Addr_ID | RDAddr_EX==RS2Addr_ID).
- MUL/DIV stall (md): L = IsDiv_EX ? DIV_LAT : MUL_LAT. md=1 when
  - IDLE & MulDiv_EX & L>1, or
  - BUSY & cnt≠0.
- Transitions:
  - IDLE & MulDiv_EX & L>1 → BUSY, cnt ← L-2.
  - BUSY & cnt≠0 → cnt ← cnt-1.
  - BUSY & cnt==0 → IDLE. This is the release cycle: md=0, and MulDiv_EX is not re-evaluated.
- Outputs (combinational from state and inputs), in priority order:
  - md=1: PCWrite_o=0, IF_ID_Write_o=0, EX_Hold_o=1, EX_MEM_Bubble_o=1, ID_EX_Bubble_o=0, IF_ID_Flush_o=0. lu and branch are both suppressed because ID is held and is re-evaluated after release.
  - else lu=1: PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1, IF_ID_Flush_o=0. A taken branch is suppressed and re-resolves next cycle.
  - else BranchTaken_ID=1: IF_ID_Flush_o=1, PCWrite_o=1, IF_ID_Write_o=1.
  - else: PCWrite_o=1, IF_ID_Write_o=1, all others 0.
- stall_cnt increments on every edge where PCWrite_o=0 and stall_cnt≠16'hFFFF. It holds at 16'hFFFF.

## Timing
- Reset (async, immediate): state=IDLE, cnt=0, stall_cnt_o=0.
- While rst_i=1, outputs are forced to PCWrite_o=1, IF_ID_Write_o=1 and all other controls 0, regardless of inputs.
- Reset while BUSY aborts the sequence. On release the controller is IDLE, and any MulDiv_EX still asserted starts a fresh sequence.
- Load-use: exactly 1 stall cycle per hazard. Next cycle, RDAddr_EX holds the bubble (MemRead_EX=0), so lu clears.
- MUL/DIV: EX occupancy is exactly L cycles, made of L-1 stall cycles plus 1 release cycle. L=1 gives zero stall and the FSM stays IDLE.
- Back-to-back MUL/DIV: the second instruction enters EX the cycle after release, sees IDLE and starts its own sequence with no gap cycle.
- Branch flush takes effect on the edge ending the cycle in which it is asserted (1-cycle penalty).

## Configuration
- HAZARD_MULDIV_EN defined: FSM, cnt, md logic, EX_Hold_o and EX_MEM_Bubble_o are as specified.
- HAZARD_MULDIV_EN undefined:
  - MulDiv_EX, IsDiv_EX, MUL_LAT and DIV_LAT are ignored, and the FSM and cnt are not built.
  - md≡0, and EX_Hold_o and EX_MEM_Bubble_o are tied to 0.
  - Load-use, branch and stall_cnt behaviour are unchanged.

## Test plan
- Load-use: MemRead_EX=1, RDAddr_EX=5, RS2Addr_ID=5 for 1 cycle → PCWrite_o=0, IF_ID_Write_o=0, ID_EX_Bubble_o=1 for exactly 1 cycle, stall_cnt_o=1. With RDAddr_EX=0 → no stall.
- Branch vs load-use: BranchTaken_ID=1 with lu active → IF_ID_Flush_o=0 that cycle. Next cycle (lu clear, branch still taken) → IF_ID_Flush_o=1, PCWrite_o=1.
- DIV: MulDiv_EX=1, IsDiv_EX=1, DIV_LAT=32 → EX_Hold_o=1 and EX_MEM_Bubble_o=1 for 31 consecutive cycles, release on the 32nd, stall_cnt_o=31. A concurrent lu or branch produces no ID_EX_Bubble_o or IF_ID_Flush_o during the hold.
- Back-to-back: MUL (MUL_LAT=4) then MUL → 3 stall, 1 release, 3 stall, 1 release. MUL_LAT=1 → no stall, FSM stays IDLE.
- Reset mid-operation: rst_i pulse at DIV cycle 10 → immediate outputs PCWrite_o=1, EX_Hold_o=0, stall_cnt_o=0. After release, state=IDLE.
- Saturation: force 65540 stall cycles → stall_cnt_o holds 16'hFFFF. With HAZARD_MULDIV_EN undefined, MulDiv_EX=1 → EX_Hold_o=0 and no stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use stalls, ID branch flushes and MUL/DIV EX occupancy.
// Define HAZARD_MULDIV_EN to build the multi-cycle MUL/DIV hold logic; without it md is constant 0.
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  RS1Addr_ID,
    input  logic [4:0]  RS2Addr_ID,
    input  logic [4:0]  RDAddr_EX,
    input  logic        MemRead_EX,
    input  logic        BranchTaken_ID,
    input  logic        MulDiv_EX,
    input  logic        IsDiv_EX,
    output logic        PCWrite_o,
    output logic        IF_ID_Write_o,
    output logic        IF_ID_Flush_o,
    output logic        ID_EX_Bubble_o,
    output logic        EX_Hold_o,
    output logic        EX_MEM_Bubble_o,
    output logic [15:0] stall_cnt_o
);

    logic        lu;
    logic        md;
    logic        stall;
    logic [15:0] stall_cnt_reg;

    assign lu = MemRead_EX && (RDAddr_EX != 5'd0) &&
                ((RDAddr_EX == RS1Addr_ID) || (RDAddr_EX == RS2Addr_ID));

`ifdef HAZARD_MULDIV_EN
    typedef enum logic {IDLE, BUSY} state_t;

    // First BUSY cycle already counts as a stall, so the counter starts at L-2.
    localparam bit         MUL_MULTI = (MUL_LAT > 1);
    localparam bit         DIV_MULTI = (DIV_LAT > 1);
    localparam logic [5:0] MUL_INIT  = MUL_MULTI ? 6'(MUL_LAT - 2) : 6'd0;
    localparam logic [5:0] DIV_INIT  = DIV_MULTI ? 6'(DIV_LAT - 2) : 6'd0;

    state_t     state_reg;
    logic [5:0] cnt_reg;
    logic       start;

    assign start = (state_reg == IDLE) && MulDiv_EX && (IsDiv_EX ? DIV_MULTI : MUL_MULTI);
    assign md    = start || ((state_reg == BUSY) && (cnt_reg != 6'd0));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= 6'd0;
        end else if (state_reg == IDLE) begin
            if (start) begin
                state_reg <= BUSY;
                cnt_reg   <= IsDiv_EX ? DIV_INIT : MUL_INIT;
            end
        end else if (cnt_reg != 6'd0) begin
            cnt_reg <= cnt_reg - 6'd1;
        end else begin
            // Release cycle: MulDiv_EX is deliberately not sampled here.
            state_reg <= IDLE;
        end
    end
`else
    logic unused_muldiv;
    assign unused_muldiv = &{1'b0, MulDiv_EX, IsDiv_EX, (MUL_LAT > 0), (DIV_LAT > 0)};
    assign md = 1'b0;
`endif

    assign stall = md || lu;

    always_comb begin
        PCWrite_o       = 1'b1;
        IF_ID_Write_o   = 1'b1;
        IF_ID_Flush_o   = 1'b0;
        ID_EX_Bubble_o  = 1'b0;
        EX_Hold_o       = 1'b0;
        EX_MEM_Bubble_o = 1'b0;
        if (rst_i) begin
            PCWrite_o = 1'b1;
        end else if (md) begin
            // ID is frozen, so any lu/branch there is re-evaluated after release.
            PCWrite_o       = 1'b0;
            IF_ID_Write_o   = 1'b0;
            EX_Hold_o       = 1'b1;
            EX_MEM_Bubble_o = 1'b1;
        end else if (lu) begin
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
        end else if (BranchTaken_ID) begin
            IF_ID_Flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_reg <= 16'd0;
        end else if (stall && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic against an
// occupancy-based reference model; also follows the HAZARD_MULDIV_EN build option.
module tb_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;
`ifdef HAZARD_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic [4:0]  RS1Addr_ID, RS2Addr_ID, RDAddr_EX;
    logic        MemRead_EX, BranchTaken_ID, MulDiv_EX, IsDiv_EX;
    logic        PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o;
    logic        EX_Hold_o, EX_MEM_Bubble_o;
    logic [15:0] stall_cnt_o;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .RS1Addr_ID     (RS1Addr_ID),
        .RS2Addr_ID     (RS2Addr_ID),
        .RDAddr_EX      (RDAddr_EX),
        .MemRead_EX     (MemRead_EX),
        .BranchTaken_ID (BranchTaken_ID),
        .MulDiv_EX      (MulDiv_EX),
        .IsDiv_EX       (IsDiv_EX),
        .PCWrite_o      (PCWrite_o),
        .IF_ID_Write_o  (IF_ID_Write_o),
        .IF_ID_Flush_o  (IF_ID_Flush_o),
        .ID_EX_Bubble_o (ID_EX_Bubble_o),
        .EX_Hold_o      (EX_Hold_o),
        .EX_MEM_Bubble_o(EX_MEM_Bubble_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    int    n_checks = 0;
    int    n_fail   = 0;
    int    occ      = 0;   // EX cycles still owned by the current MUL/DIV (0 = none)
    int    exp_cnt  = 0;
    int    hold_seen = 0;
    string phase    = "reset";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h at %0t", phase, tag, obs, exp, $time);
        end
    endtask

    function automatic logic [5:0] ctl_now();
        return {PCWrite_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Bubble_o, EX_Hold_o, EX_MEM_Bubble_o};
    endfunction

    task automatic set_in(input int rs1, input int rs2, input int rd, input bit mr,
                          input bit br, input bit muldiv, input bit isdiv);
        RS1Addr_ID     = 5'(rs1);
        RS2Addr_ID     = 5'(rs2);
        RDAddr_EX      = 5'(rd);
        MemRead_EX     = mr;
        BranchTaken_ID = br;
        MulDiv_EX      = muldiv;
        IsDiv_EX       = isdiv;
    endtask

    // Called at a falling edge with inputs applied; checks this cycle, then advances one clock.
    task automatic step();
        int         occ_cur;
        bit         md, lu;
        logic [5:0] exp_ctl;
        #1;
        occ_cur = occ;
        if (MD_EN && occ == 0 && MulDiv_EX)
            occ_cur = IsDiv_EX ? DIV_LAT : MUL_LAT;
        md = (occ_cur > 1);
        lu = MemRead_EX && RDAddr_EX != 0 && (RDAddr_EX == RS1Addr_ID || RDAddr_EX == RS2Addr_ID);
        if (md)                  exp_ctl = 6'b000011;
        else if (lu)             exp_ctl = 6'b000100;
        else if (BranchTaken_ID) exp_ctl = 6'b111000;
        else                     exp_ctl = 6'b110000;
        check("ctl", 32'(ctl_now()), 32'(exp_ctl));
        check("stall_cnt", 32'(stall_cnt_o), 32'(exp_cnt));
        if (EX_Hold_o) hold_seen++;
        @(posedge clk);
        occ = (occ_cur > 0) ? occ_cur - 1 : 0;
        if (!exp_ctl[5] && exp_cnt < 65535) exp_cnt++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        check("rst_ctl", 32'(ctl_now()), 32'(6'b110000));
        check("rst_cnt", 32'(stall_cnt_o), 32'd0);
        occ     = 0;
        exp_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0);
        do_reset();
        $display("scenario reset done, checks=%0d", n_checks);

        phase = "loaduse";
        set_in(5, 5, 5, 1, 0, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0); step();
        check("cnt_after_lu", 32'(stall_cnt_o), 32'd1);
        set_in(0, 0, 0, 1, 0, 0, 0); step();   // rd = x0 never stalls
        $display("scenario load-use done, checks=%0d", n_checks);

        phase = "branch_lu";
        set_in(7, 2, 7, 1, 1, 0, 0); step();
        set_in(7, 2, 0, 0, 1, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0, 0); step();
        $display("scenario branch-vs-load-use done, checks=%0d", n_checks);

        phase = "div";
        hold_seen = 0;
        set_in(3, 3, 3, 1, 1, 1, 1);
        for (int i = 0; i < DIV_LAT; i++) step();
        set_in(0, 0, 0, 0, 0, 0, 0); step();
        check("div_hold_cycles", 32'(hold_seen), MD_EN ? 32'(DIV_LAT - 1) : 32'd0);
        $display("scenario div done, checks=%0d", n_checks);

        phase = "mul_b2b";
        hold_seen = 0;
        set_in(0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 2 * MUL_LAT; i++) step();
        set_in(0, 0, 0, 0, 0, 0, 0); step();
        check("mul_hold_cycles", 32'(hold_seen), MD_EN ? 32'(2 * (MUL_LAT - 1)) : 32'd0);
        $display("scenario back-to-back mul done, checks=%0d", n_checks);

        phase = "rst_mid_div";
        set_in(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) step();
        do_reset();
        for (int i = 0; i < 4; i++) step();   // still requesting: fresh sequence from IDLE
        set_in(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < DIV_LAT; i++) step();
        $display("scenario reset-mid-div done, checks=%0d", n_checks);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 499) == 0) do_reset();
            else step();
        end
        $display("scenario random done, checks=%0d", n_checks);

        phase = "saturate";
        do_reset();
        set_in(5, 0, 5, 1, 0, 0, 0);
        for (int i = 0; i < 65540; i++) step();
        check("sat_value", 32'(stall_cnt_o), 32'hFFFF);
        set_in(0, 0, 0, 0, 0, 0, 0); step();
        $display("scenario saturation done, checks=%0d", n_checks);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
